// File: rtl/ntt_stage_sched_pkg.sv
// Shared definitions for the NTT stage scheduler: FSM state encodings,
// add/sub slot encodings (must match the add/sub unit's sel input) and the
// datapath width define reused by the surrounding design.
// Optional feature macro used by the top: NTT_STAGE_SCHED_STATS_EN.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 32
`endif

package ntt_stage_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Slot 0 of a pair drives the unit as an adder, slot 1 as a subtractor.
  localparam logic SLOT_ADD = 1'b0;
  localparam logic SLOT_SUB = 1'b1;

endpackage

// File: rtl/ntt_addr_gen.sv
// Butterfly pair address mapping for one (stage, k) point.
// half  = N >> (stage+1)
// addr0 = (k >> (LOG_N-1-stage)) * 2*half + (k & (half-1))
// addr1 = addr0 + half
// Both products are powers of two, so everything reduces to shifts and masks.
module ntt_addr_gen #(
  parameter  int LOG_N = 8,
  localparam int SW    = $clog2(LOG_N) + 1
) (
  input  logic [SW-1:0]    i_stage,
  input  logic [LOG_N-1:0] i_k,
  output logic [LOG_N-1:0] o_addr0,
  output logic [LOG_N-1:0] o_addr1
);

  localparam logic [SW-1:0]    LAST = SW'(LOG_N - 1);
  localparam logic [LOG_N-1:0] ONE  = LOG_N'(1);

  logic [SW-1:0]    w_sh;
  logic [LOG_N-1:0] w_half;
  logic [LOG_N-1:0] w_hi;
  logic [LOG_N-1:0] w_lo;

  // Group index scaled by the group span, plus offset inside the group.
  always_comb begin
    w_sh    = LAST - i_stage;
    w_half  = ONE << w_sh;
    w_hi    = (i_k >> w_sh) << (w_sh + SW'(1));
    w_lo    = i_k & (w_half - ONE);
    o_addr0 = w_hi | w_lo;
    o_addr1 = o_addr0 + w_half;
  end

endmodule

// File: rtl/ntt_stage_sched.sv
// Sequencer driving one shared modular add/sub unit through every butterfly
// stage of an in-place N-point transform held in an external dual-port RAM.
// Every output is a flop: the FSM computes the next cycle's state and issue
// decision combinationally and registers them, so rd_en/addresses line up
// with the RUN cycles they belong to. hold is sampled at the clock edge that
// would register an issue and suppresses that issue.
// Handshake: no back-pressure from the RAM or unit; rd_en at cycle c means
// both RAM ports read at c, sel is valid at c+1 with the read data, and the
// unit result is written at c+1+LAT (wr_en/wr_addr).
// Optional feature: NTT_STAGE_SCHED_STATS_EN adds the 'cycles' busy counter.
module ntt_stage_sched
  import ntt_stage_sched_pkg::*;
#(
  parameter  int LOG_N = 8,
  parameter  int LAT   = 1,
  localparam int SW    = $clog2(LOG_N) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [`DATA_SIZE_ARB-1:0] q_in,
  input  logic                      hold,
  output logic [`DATA_SIZE_ARB-1:0] q,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [LOG_N-1:0]          rd_addr0,
  output logic [LOG_N-1:0]          rd_addr1,
  output logic                      sel,
  output logic                      wr_en,
  output logic [LOG_N-1:0]          wr_addr,
  output logic [SW-1:0]             stage,
  output state_t                    dbg_state
`ifdef NTT_STAGE_SCHED_STATS_EN
  ,
  output logic [31:0]               cycles
`endif
);

  localparam int               DRW        = (LAT > 1) ? $clog2(LAT + 1) : 1;
  localparam logic [LOG_N:0]   N_SLOTS    = {1'b1, {LOG_N{1'b0}}};
  localparam logic [SW-1:0]    LAST_STAGE = SW'(LOG_N - 1);
  localparam logic [DRW-1:0]   DRAIN_LAST = DRW'(LAT);

  state_t                    r_state;
  logic [SW-1:0]             r_stage;
  logic [LOG_N:0]            r_cnt;      // slots issued in this stage; k = cnt>>1, slot = cnt[0]
  logic [DRW-1:0]            r_drain;
  logic [`DATA_SIZE_ARB-1:0] r_q;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_rd_en;
  logic                      r_rd_slot;
  logic [LOG_N-1:0]          r_rd_addr0;
  logic [LOG_N-1:0]          r_rd_addr1;
  logic                      r_sel;
  logic [LAT:0]              r_wp_valid;
  logic [LAT:0][LOG_N-1:0]   r_wp_addr;

  state_t                    w_state_nxt;
  logic [SW-1:0]             w_stage_nxt;
  logic [LOG_N:0]            w_cnt_base;
  logic [LOG_N:0]            w_cnt_nxt;
  logic [DRW-1:0]            w_drain_nxt;
  logic                      w_can_issue;
  logic                      w_issue;
  logic [LOG_N-1:0]          w_addr0;
  logic [LOG_N-1:0]          w_addr1;
  logic [LOG_N-1:0]          w_wb_addr;

  ntt_addr_gen #(.LOG_N(LOG_N)) u_addr_gen (
    .i_stage (w_stage_nxt),
    .i_k     (w_cnt_base[LOG_N:1]),
    .o_addr0 (w_addr0),
    .o_addr1 (w_addr1)
  );

  // Next-state and next-cycle issue decision.
  always_comb begin
    w_state_nxt = r_state;
    w_stage_nxt = r_stage;
    w_cnt_base  = r_cnt;
    w_drain_nxt = r_drain;
    w_can_issue = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_stage_nxt = '0;
          w_cnt_base  = '0;
          w_can_issue = 1'b1;
        end
      end
      ST_RUN: begin
        if (r_cnt == N_SLOTS) begin
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = '0;
        end else begin
          w_can_issue = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (r_drain == DRAIN_LAST) begin
          if (r_stage == LAST_STAGE) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_RUN;
            w_stage_nxt = r_stage + SW'(1);
            w_cnt_base  = '0;
            w_can_issue = 1'b1;
          end
        end else begin
          w_drain_nxt = r_drain + DRW'(1);
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    w_issue   = w_can_issue & ~hold;
    w_cnt_nxt = w_cnt_base + {{LOG_N{1'b0}}, w_issue};
  end

  // FSM state, counters and registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_stage    <= '0;
      r_cnt      <= '0;
      r_drain    <= '0;
      r_q        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_slot  <= SLOT_ADD;
      r_rd_addr0 <= '0;
      r_rd_addr1 <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_stage <= w_stage_nxt;
      r_cnt   <= w_cnt_nxt;
      r_drain <= w_drain_nxt;
      r_busy  <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
      r_done  <= (w_state_nxt == ST_DONE);
      r_rd_en <= w_issue;
      if (r_state == ST_IDLE && start) r_q <= q_in;
      if (w_issue) begin
        r_rd_slot  <= w_cnt_base[0];
        r_rd_addr0 <= w_addr0;
        r_rd_addr1 <= w_addr1;
      end
    end
  end

  assign w_wb_addr = (r_rd_slot == SLOT_SUB) ? r_rd_addr1 : r_rd_addr0;

  // sel follows read data; write-back pipe delays {valid, addr} by 1+LAT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel      <= SLOT_ADD;
      r_wp_valid <= '0;
      r_wp_addr  <= '0;
    end else begin
      r_sel      <= r_rd_en & r_rd_slot;
      r_wp_valid <= {r_wp_valid[LAT-1:0], r_rd_en};
      r_wp_addr  <= {r_wp_addr[LAT-1:0], w_wb_addr};
    end
  end

`ifdef NTT_STAGE_SCHED_STATS_EN
  logic [31:0] r_cycles;

  // Busy-cycle counter, cleared by an accepted start and frozen after done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycles <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_cycles <= '0;
    end else if (r_busy) begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  assign cycles = r_cycles;
`endif

  assign q         = r_q;
  assign busy      = r_busy;
  assign done      = r_done;
  assign rd_en     = r_rd_en;
  assign rd_addr0  = r_rd_addr0;
  assign rd_addr1  = r_rd_addr1;
  assign sel       = r_sel;
  assign wr_en     = r_wp_valid[LAT];
  assign wr_addr   = r_wp_addr[LAT];
  assign stage     = r_stage;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ntt_stage_sched.sv
// Bench for ntt_stage_sched: DUT A (LOG_N=3, LAT=1) and DUT B (LOG_N=3, LAT=3).
// Expected reads, sel values, writes and done events are pushed into queues
// when a start is driven; per-DUT monitors pop and compare on DUT outputs.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 32
`endif

module tb_ntt_stage_sched;
  import ntt_stage_sched_pkg::*;

  localparam int LOG_N = 3;
  localparam int SW    = $clog2(LOG_N) + 1;
  localparam int DW    = `DATA_SIZE_ARB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          reset_a, start_a, hold_a, reset_b, start_b, hold_b;
  logic [DW-1:0] q_in;

  logic [DW-1:0] a_q, b_q;
  logic a_busy, a_done, a_rd_en, a_sel, a_wr_en, b_busy, b_done, b_rd_en, b_sel, b_wr_en;
  logic [LOG_N-1:0] a_rd_addr0, a_rd_addr1, a_wr_addr, b_rd_addr0, b_rd_addr1, b_wr_addr;
  logic [SW-1:0] a_stage, b_stage;
  state_t a_dbg, b_dbg;
`ifdef NTT_STAGE_SCHED_STATS_EN
  logic [31:0] a_cycles, b_cycles;
`endif

  ntt_stage_sched #(.LOG_N(LOG_N), .LAT(1)) u_dut_a (
    .clk(clk), .reset(reset_a), .start(start_a), .q_in(q_in), .hold(hold_a),
    .q(a_q), .busy(a_busy), .done(a_done), .rd_en(a_rd_en),
    .rd_addr0(a_rd_addr0), .rd_addr1(a_rd_addr1), .sel(a_sel),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .stage(a_stage), .dbg_state(a_dbg)
`ifdef NTT_STAGE_SCHED_STATS_EN
    , .cycles(a_cycles)
`endif
  );

  ntt_stage_sched #(.LOG_N(LOG_N), .LAT(3)) u_dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .q_in(q_in), .hold(hold_b),
    .q(b_q), .busy(b_busy), .done(b_done), .rd_en(b_rd_en),
    .rd_addr0(b_rd_addr0), .rd_addr1(b_rd_addr1), .sel(b_sel),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .stage(b_stage), .dbg_state(b_dbg)
`ifdef NTT_STAGE_SCHED_STATS_EN
    , .cycles(b_cycles)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  // Entries: rd {cycle, stage, addr0, addr1}; sel/wr {cycle, value}; done {cycle, busy_len, q}
  logic [95:0] a_rd_q[$], a_sel_q[$], a_wr_q[$], a_dn_q[$];
  logic [95:0] b_rd_q[$], b_sel_q[$], b_wr_q[$], b_dn_q[$];

  // Hand-computed butterfly pairs for N=8: {addr0, addr1} nibbles per stage.
  logic [7:0] pair_tbl [3][4] = '{'{8'h04, 8'h15, 8'h26, 8'h37},
                                  '{8'h02, 8'h13, 8'h46, 8'h57},
                                  '{8'h01, 8'h23, 8'h45, 8'h67}};

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: output event at cycle %0d, expected none", name, cyc);
  endtask

  // Push the full expected event stream of one transform started so that
  // its first busy cycle is 'base'. A hold of hold_len cycles lands just
  // before slot hold_slot of stage hold_stage.
  task automatic push_run(input bit is_b, input int base, input int lat,
                          input int hold_stage, input int hold_slot, input int hold_len,
                          input logic [DW-1:0] qv);
    int per, off, c;
    logic [3:0] a0, a1;
    logic slot;
    per = 8 + 1 + lat;
    off = 0;
    for (int s = 0; s < 3; s++) begin
      for (int j = 0; j < 8; j++) begin
        if (s == hold_stage && j == hold_slot) off += hold_len;
        c    = base + s * per + j + off;
        a0   = pair_tbl[s][j / 2][7:4];
        a1   = pair_tbl[s][j / 2][3:0];
        slot = (j % 2) == 1;
        if (!is_b) begin
          a_rd_q.push_back({32'(c), 32'(s), 16'(a0), 16'(a1)});
          a_sel_q.push_back({32'(c + 1), 64'(slot)});
          a_wr_q.push_back({32'(c + 1 + lat), 64'(slot ? a1 : a0)});
        end else begin
          b_rd_q.push_back({32'(c), 32'(s), 16'(a0), 16'(a1)});
          b_sel_q.push_back({32'(c + 1), 64'(slot)});
          b_wr_q.push_back({32'(c + 1 + lat), 64'(slot ? a1 : a0)});
        end
      end
    end
    if (!is_b) a_dn_q.push_back({32'(base + 3 * per + off), 32'(3 * per + off), 32'(qv)});
    else       b_dn_q.push_back({32'(base + 3 * per + off), 32'(3 * per + off), 32'(qv)});
  endtask

  // ---------------- monitors ----------------
  int   a_blen = 0, b_blen = 0;
  logic a_bprev = 1'b0, b_bprev = 1'b0;

  always begin
    logic [95:0] e;
    @(posedge clk);
    #1;
    if (a_busy) a_blen = a_bprev ? a_blen + 1 : 1;
    a_bprev = a_busy;
    if (a_rd_en) begin
      if (a_rd_q.size() == 0) unexpected("a_rd");
      else check("a_rd", {32'(cyc), 32'(a_stage), 16'(a_rd_addr0), 16'(a_rd_addr1)}, a_rd_q.pop_front());
    end
    if (a_sel_q.size() != 0 && a_sel_q[0][95:64] == 32'(cyc))
      check("a_sel", {32'(cyc), 64'(a_sel)}, a_sel_q.pop_front());
    if (a_wr_en) begin
      if (a_wr_q.size() == 0) unexpected("a_wr");
      else check("a_wr", {32'(cyc), 64'(a_wr_addr)}, a_wr_q.pop_front());
    end
    if (a_done) begin
      if (a_dn_q.size() == 0) unexpected("a_done");
      else begin
        e = a_dn_q.pop_front();
        check("a_done", {32'(cyc), 32'(a_blen), 32'(a_q)}, e);
`ifdef NTT_STAGE_SCHED_STATS_EN
        check("a_cycles", 96'(a_cycles), 96'(e[63:32]));
`endif
      end
    end
  end

  always begin
    logic [95:0] e;
    @(posedge clk);
    #1;
    if (b_busy) b_blen = b_bprev ? b_blen + 1 : 1;
    b_bprev = b_busy;
    if (b_rd_en) begin
      if (b_rd_q.size() == 0) unexpected("b_rd");
      else check("b_rd", {32'(cyc), 32'(b_stage), 16'(b_rd_addr0), 16'(b_rd_addr1)}, b_rd_q.pop_front());
    end
    if (b_sel_q.size() != 0 && b_sel_q[0][95:64] == 32'(cyc))
      check("b_sel", {32'(cyc), 64'(b_sel)}, b_sel_q.pop_front());
    if (b_wr_en) begin
      if (b_wr_q.size() == 0) unexpected("b_wr");
      else check("b_wr", {32'(cyc), 64'(b_wr_addr)}, b_wr_q.pop_front());
    end
    if (b_done) begin
      if (b_dn_q.size() == 0) unexpected("b_done");
      else begin
        e = b_dn_q.pop_front();
        check("b_done", {32'(cyc), 32'(b_blen), 32'(b_q)}, e);
`ifdef NTT_STAGE_SCHED_STATS_EN
        check("b_cycles", 96'(b_cycles), 96'(e[63:32]));
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic int pending();
    return a_rd_q.size() + a_sel_q.size() + a_wr_q.size() + a_dn_q.size() +
           b_rd_q.size() + b_sel_q.size() + b_wr_q.size() + b_dn_q.size();
  endfunction

  task automatic wait_quiet(input int limit);
    int n = 0;
    while (pending() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) begin
      n_checks++;
      n_err++;
      $display("FAIL drain_timeout: %0d events pending after %0d cycles, expected 0", pending(), limit);
    end
    repeat (4) @(negedge clk);
  endtask

  // Drives a one-cycle start on DUT A and returns the first busy cycle.
  task automatic start_a_run(input logic [DW-1:0] qv, input int hs, input int hp, input int hl,
                             output int base);
    @(negedge clk);
    base = cyc + 1;
    push_run(1'b0, base, 1, hs, hp, hl, qv);
    q_in    = qv;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  function automatic logic [95:0] a_outs();
    return 96'({a_busy, a_done, a_rd_en, a_wr_en, a_sel, a_rd_addr0, a_rd_addr1, a_wr_addr, a_stage, a_q});
  endfunction

  function automatic logic [95:0] b_outs();
    return 96'({b_busy, b_done, b_rd_en, b_wr_en, b_sel, b_rd_addr0, b_rd_addr1, b_wr_addr, b_stage, b_q});
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int base;
    reset_a = 1'b1; reset_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    hold_a  = 1'b0; hold_b  = 1'b0;
    q_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("a_reset_outs",  a_outs(), 96'(0));
    check("b_reset_outs",  b_outs(), 96'(0));
    check("a_reset_state", 96'(a_dbg), 96'(ST_IDLE));
    @(negedge clk);
    reset_a = 1'b0; reset_b = 1'b0;
    repeat (2) @(negedge clk);

    // Plain transform: all three stages, 30 busy cycles, done on cycle 31.
    start_a_run(DW'(251), -1, -1, 0, base);
    wait_quiet(100);
    check("a_q_latched", 96'(a_q), 96'(251));
    check("a_idle_after_done", 96'({a_busy, a_done}), 96'(0));

    // hold for three issue opportunities before stage 1, slot 3.
    start_a_run(DW'(32'h1234), 1, 3, 3, base);
    while (cyc < base + 10 + 3 - 1) @(negedge clk);
    hold_a = 1'b1;
    repeat (3) @(negedge clk);
    hold_a = 1'b0;
    wait_quiet(100);

    // Reset during stage 1 RUN: outputs clear, nothing further is written.
    start_a_run(DW'(77), -1, -1, 0, base);
    while (cyc < base + 10 + 2) @(negedge clk);
    reset_a = 1'b1;
    a_rd_q.delete(); a_sel_q.delete(); a_wr_q.delete(); a_dn_q.delete();
    @(posedge clk);
    #1;
    check("a_midrun_reset_outs",  a_outs(), 96'(0));
    check("a_midrun_reset_state", 96'(a_dbg), 96'(ST_IDLE));
    @(negedge clk);
    reset_a = 1'b0;
    repeat (8) @(negedge clk);

    // Full transform again after the reset.
    start_a_run(DW'(32'h55), -1, -1, 0, base);
    wait_quiet(100);

    // LAT=3: 4-cycle drain, 36 busy cycles; starts mid-run and in DONE ignored.
    @(negedge clk);
    base = cyc + 1;
    push_run(1'b1, base, 3, -1, -1, 0, DW'(97));
    q_in    = DW'(97);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    while (cyc < base + 5) @(negedge clk);
    q_in    = DW'(13);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    while (cyc < base + 36) @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    wait_quiet(100);
    repeat (6) @(negedge clk);
    check("b_q_kept",      96'(b_q), 96'(97));
    check("b_idle_at_end", 96'(b_dbg), 96'(ST_IDLE));

    check("a_rd_left",  96'(a_rd_q.size()),  96'(0));
    check("a_wr_left",  96'(a_wr_q.size()),  96'(0));
    check("a_dn_left",  96'(a_dn_q.size()),  96'(0));
    check("b_rd_left",  96'(b_rd_q.size()),  96'(0));
    check("b_wr_left",  96'(b_wr_q.size()),  96'(0));
    check("b_dn_left",  96'(b_dn_q.size()),  96'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d, expected finish earlier", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
